regfile_wb_ctrl: RTL and testbench

Write-side controller for the 32x32 register file. It merges two writeback producers into the register file's single synchronous write port (we/wa/wd): a non-stallable ALU path and a stallable load-return path buffered in a small FIFO. It also provides forwarding for two read addresses, so the decode stage never reads a stale register while a write is still pending.

---
 rtl/regfile_wb_ctrl.sv | 140 ++++++++++++++
 tb/tb_regfile_wb_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: write-side controller for the 32x32 register file.
// Merges a non-stallable ALU writeback and a FIFO-buffered load-return
// writeback onto the single registered write port, and forwards pending
// writes to the two decode read ports.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   alu_valid/alu_wa/alu_wd     ALU writeback (always accepted, has priority)
//   ld_valid/ld_ready/ld_wa/ld_wd  load-return writeback (valid/ready)
//   rf_we/rf_wa/rf_wd           registered register-file write port
//   ra1/ra2                     decode read addresses
//   fwd1_hit/fwd1_data,
//   fwd2_hit/fwd2_data          combinational forwarding results
//   occupancy                   FIFO entry count, squashed entries included
module regfile_wb_ctrl #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 5,
   parameter int unsigned DW    = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     alu_valid,
   input  logic [AW-1:0]            alu_wa,
   input  logic [DW-1:0]            alu_wd,
   input  logic                     ld_valid,
   output logic                     ld_ready,
   input  logic [AW-1:0]            ld_wa,
   input  logic [DW-1:0]            ld_wd,
   output logic                     rf_we,
   output logic [AW-1:0]            rf_wa,
   output logic [DW-1:0]            rf_wd,
   input  logic [AW-1:0]            ra1,
   input  logic [AW-1:0]            ra2,
   output logic                     fwd1_hit,
   output logic [DW-1:0]            fwd1_data,
   output logic                     fwd2_hit,
   output logic [DW-1:0]            fwd2_data,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned OW = PW + 1;

   logic [DEPTH-1:0] ent_valid;
   logic [AW-1:0]    ent_wa [DEPTH];
   logic [DW-1:0]    ent_wd [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;

   logic push;
   logic pop;
   logic alu_kill;

   // Full is judged on current occupancy only; a same-cycle pop does not help.
   assign ld_ready = (occupancy != OW'(DEPTH));
   assign push     = ld_valid && ld_ready;
   assign pop      = !alu_valid && (occupancy != '0);
   // An ALU write to a nonzero register is younger than every queued load.
   assign alu_kill = alu_valid && (alu_wa != '0);

   // FIFO control: pointers, occupancy and per-entry valid (squash) bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
         ent_valid <= '0;
      end else begin
         if (alu_kill) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
               if (ent_wa[i] == alu_wa) ent_valid[i] <= 1'b0;
            end
         end
         if (pop) begin
            ent_valid[rd_ptr] <= 1'b0;
            rd_ptr            <= rd_ptr + PW'(1);
         end
         // A load landing alongside a matching ALU write is already stale.
         if (push) begin
            ent_valid[wr_ptr] <= !(alu_kill && (ld_wa == alu_wa));
            wr_ptr            <= wr_ptr + PW'(1);
         end
         if (push && !pop)      occupancy <= occupancy + OW'(1);
         else if (pop && !push) occupancy <= occupancy - OW'(1);
      end
   end

   // FIFO payload storage; no reset needed, guarded by valid/occupancy.
   always_ff @(posedge clk) begin
      if (push) begin
         ent_wa[wr_ptr] <= ld_wa;
         ent_wd[wr_ptr] <= ld_wd;
      end
   end

   // Output stage: ALU wins, else drain one FIFO entry, else idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_we <= 1'b0;
         rf_wa <= '0;
         rf_wd <= '0;
      end else if (alu_valid) begin
         rf_we <= (alu_wa != '0);
         rf_wa <= alu_wa;
         rf_wd <= alu_wd;
      end else if (pop) begin
         rf_we <= ent_valid[rd_ptr] && (ent_wa[rd_ptr] != '0);
         rf_wa <= ent_wa[rd_ptr];
         rf_wd <= ent_wd[rd_ptr];
      end else begin
         rf_we <= 1'b0;
      end
   end

   // Forwarding lookup: staged write first, then FIFO oldest to youngest so
   // the youngest valid match overrides everything before it.
   function automatic logic [DW:0] fwd_lookup(input logic [AW-1:0] ra);
      logic          hit;
      logic [DW-1:0] data;
      logic [PW-1:0] idx;
      hit  = rf_we && (rf_wa == ra);
      data = hit ? rf_wd : '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = rd_ptr + PW'(i);
         if ((OW'(i) < occupancy) && ent_valid[idx] && (ent_wa[idx] == ra)) begin
            hit  = 1'b1;
            data = ent_wd[idx];
         end
      end
      if (ra == '0) begin
         hit  = 1'b0;
         data = '0;
      end
      return {hit, data};
   endfunction

   assign {fwd1_hit, fwd1_data} = fwd_lookup(ra1);
   assign {fwd2_hit, fwd2_data} = fwd_lookup(ra2);

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_regfile_wb_ctrl;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned AW    = 5;
   localparam int unsigned DW    = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          alu_valid;
   logic [AW-1:0] alu_wa;
   logic [DW-1:0] alu_wd;
   logic          ld_valid;
   logic          ld_ready;
   logic [AW-1:0] ld_wa;
   logic [DW-1:0] ld_wd;
   logic          rf_we;
   logic [AW-1:0] rf_wa;
   logic [DW-1:0] rf_wd;
   logic [AW-1:0] ra1;
   logic [AW-1:0] ra2;
   logic          fwd1_hit;
   logic [DW-1:0] fwd1_data;
   logic          fwd2_hit;
   logic [DW-1:0] fwd2_data;
   logic [2:0]    occupancy;

   regfile_wb_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_valid(alu_valid), .alu_wa(alu_wa), .alu_wd(alu_wd),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_wa(ld_wa), .ld_wd(ld_wd),
      .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
      .ra1(ra1), .ra2(ra2),
      .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
      .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
      .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   // Reference model: pending loads as a queue, plus the staged write.
   typedef struct {
      logic          v;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
   } ent_t;

   ent_t          q[$];
   logic          m_we;
   logic [AW-1:0] m_wa;
   logic [DW-1:0] m_wd;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_we = 1'b0;
      m_wa = '0;
      m_wd = '0;
   endtask

   // Youngest valid queued load wins, then the staged write; reg 0 never hits.
   task automatic model_fwd(input logic [AW-1:0] ra, output logic hit, output logic [DW-1:0] data);
      hit  = 1'b0;
      data = '0;
      if (ra != 0) begin
         for (int i = q.size() - 1; i >= 0; i--) begin
            if (!hit && q[i].v && q[i].wa == ra) begin
               hit  = 1'b1;
               data = q[i].wd;
            end
         end
         if (!hit && m_we && m_wa == ra) begin
            hit  = 1'b1;
            data = m_wd;
         end
      end
   endtask

   task automatic model_step();
      logic acc;
      ent_t e;
      acc = ld_valid && (q.size() != DEPTH);
      if (alu_valid) begin
         m_we = (alu_wa != 0);
         m_wa = alu_wa;
         m_wd = alu_wd;
         if (alu_wa != 0)
            foreach (q[i]) if (q[i].wa == alu_wa) q[i].v = 1'b0;
      end else if (q.size() > 0) begin
         e    = q.pop_front();
         m_we = e.v && (e.wa != 0);
         m_wa = e.wa;
         m_wd = e.wd;
      end else begin
         m_we = 1'b0;
      end
      if (acc) begin
         e.v  = !(alu_valid && alu_wa != 0 && alu_wa == ld_wa);
         e.wa = ld_wa;
         e.wd = ld_wd;
         q.push_back(e);
      end
   endtask

   task automatic drive(input logic av, input logic [AW-1:0] awa, input logic [DW-1:0] awd,
                        input logic lv, input logic [AW-1:0] lwa, input logic [DW-1:0] lwd,
                        input logic [AW-1:0] r1, input logic [AW-1:0] r2);
      alu_valid = av;  alu_wa = awa; alu_wd = awd;
      ld_valid  = lv;  ld_wa  = lwa; ld_wd  = lwd;
      ra1 = r1;  ra2 = r2;
   endtask

   // One clock: check combinational outputs, clock, check registered outputs.
   // Entered and left at the falling edge.
   task automatic cycle();
      logic          h;
      logic [DW-1:0] d;
      #1;
      check("ld_ready", 64'(ld_ready), 64'(q.size() != DEPTH));
      check("occ_pre", 64'(occupancy), 64'(q.size()));
      model_fwd(ra1, h, d);
      check("fwd1_hit", 64'(fwd1_hit), 64'(h));
      check("fwd1_data", 64'(fwd1_data), 64'(d));
      model_fwd(ra2, h, d);
      check("fwd2_hit", 64'(fwd2_hit), 64'(h));
      check("fwd2_data", 64'(fwd2_data), 64'(d));
      @(posedge clk);
      model_step();
      #1;
      check("rf_we", 64'(rf_we), 64'(m_we));
      check("rf_wa", 64'(rf_wa), 64'(m_wa));
      check("rf_wd", 64'(rf_wd), 64'(m_wd));
      check("occ_post", 64'(occupancy), 64'(q.size()));
      @(negedge clk);
   endtask

   task automatic idle(input logic [AW-1:0] r1, input logic [AW-1:0] r2);
      drive(1'b0, '0, '0, 1'b0, '0, '0, r1, r2);
   endtask

   initial begin
      rst_n = 1'b0;
      idle(5'd5, 5'd7);
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset then idle
      #1;
      check("rst_rf_we", 64'(rf_we), 64'd0);
      check("rst_occ", 64'(occupancy), 64'd0);
      check("rst_ld_ready", 64'(ld_ready), 64'd1);
      check("rst_fwd1", 64'(fwd1_hit), 64'd0);
      check("rst_fwd2", 64'(fwd2_hit), 64'd0);
      @(negedge clk);
      cycle();

      // ALU path, then ALU write to register 0
      drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 5'd5, 5'd0);
      cycle();
      check("alu_we", 64'(rf_we), 64'd1);
      check("alu_wa", 64'(rf_wa), 64'd5);
      check("alu_wd", 64'(rf_wd), 64'hDEADBEEF);
      check("alu_fwd1_hit", 64'(fwd1_hit), 64'd1);
      check("alu_fwd1_data", 64'(fwd1_data), 64'hDEADBEEF);
      drive(1'b1, 5'd0, 32'h1234, 1'b0, '0, '0, 5'd0, 5'd0);
      cycle();
      check("alu_r0_we", 64'(rf_we), 64'd0);

      // Fill under ALU traffic, then drain with a held 5th load
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 5'd20, 32'(k), 1'b1, 5'(k + 1), 32'h10 + 32'(k), 5'd3, 5'd20);
         cycle();
      end
      check("fill_occ", 64'(occupancy), 64'd4);
      check("fill_ready", 64'(ld_ready), 64'd0);
      drive(1'b1, 5'd20, 32'h99, 1'b1, 5'd5, 32'h14, 5'd5, 5'd2);
      cycle();
      check("held_occ", 64'(occupancy), 64'd4);
      drive(1'b0, '0, '0, 1'b1, 5'd5, 32'h14, 5'd5, 5'd4);
      cycle();
      check("drain1_wa", 64'(rf_wa), 64'd1);
      check("drain1_occ", 64'(occupancy), 64'd3);
      cycle();
      check("drain2_wa", 64'(rf_wa), 64'd2);
      check("drain2_occ", 64'(occupancy), 64'd3);
      idle(5'd5, 5'd4);
      cycle();
      check("drain3_wa", 64'(rf_wa), 64'd3);
      cycle();
      check("drain4_wa", 64'(rf_wa), 64'd4);
      cycle();
      check("drain5_wa", 64'(rf_wa), 64'd5);
      check("drain5_wd", 64'(rf_wd), 64'h14);

      // Squash of a queued load by a younger ALU write
      drive(1'b0, '0, '0, 1'b1, 5'd7, 32'h1, 5'd0, 5'd7);
      cycle();
      drive(1'b1, 5'd7, 32'h2, 1'b0, '0, '0, 5'd0, 5'd7);
      cycle();
      check("sq_wd", 64'(rf_wd), 64'h2);
      check("sq_fwd2_data", 64'(fwd2_data), 64'h2);
      idle(5'd0, 5'd7);
      cycle();
      check("sq_bubble_we", 64'(rf_we), 64'd0);
      check("sq_fwd2_hit", 64'(fwd2_hit), 64'd0);

      // Forward priority: staged 9/A, FIFO holds 9/B then 9/C
      drive(1'b1, 5'd30, 32'h0, 1'b1, 5'd9, 32'hA, 5'd9, 5'd0);
      cycle();
      drive(1'b1, 5'd30, 32'h0, 1'b1, 5'd9, 32'hB, 5'd9, 5'd0);
      cycle();
      drive(1'b1, 5'd30, 32'h0, 1'b1, 5'd9, 32'hC, 5'd9, 5'd0);
      cycle();
      idle(5'd9, 5'd0);
      cycle();
      check("prio_staged_wd", 64'(rf_wd), 64'hA);
      check("prio_fwd1_data", 64'(fwd1_data), 64'hC);
      cycle();
      cycle();

      // Async reset mid-drain with three entries still queued
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 5'd25, 32'h0, 1'b1, 5'(11 + k), 32'h40 + 32'(k), 5'd12, 5'd13);
         cycle();
      end
      idle(5'd12, 5'd13);
      cycle();
      check("pre_rst_occ", 64'(occupancy), 64'd3);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("arst_rf_we", 64'(rf_we), 64'd0);
      check("arst_occ", 64'(occupancy), 64'd0);
      check("arst_ready", 64'(ld_ready), 64'd1);
      repeat (2) @(posedge clk);
      #1;
      check("arst_hold_we", 64'(rf_we), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) cycle();

      // Random traffic on a small address range to provoke collisions
      for (int n = 0; n < 600; n++) begin
         drive(($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)), $urandom(),
               ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom(),
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         cycle();
      end
      idle(5'd0, 5'd0);
      repeat (DEPTH + 2) cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
